muldiv_unit: RTL and testbench

//   Multi-cycle integer MULT/MULTU/DIV/DIVU engine for the execute stage. Takes
//   the multiply/divide path out of the single-cycle ALU path. Produces a {hi,lo}

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine producing a {hi,lo} result pair.
// Multiply waits MUL_CYCLES cycles; divide is restoring on magnitudes plus a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               in_sgn;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]     rem_sh, diff;

  always_comb begin
    in_sgn   = ~op[0];
    abs_a_in = (in_sgn && a[WIDTH-1]) ? -a : a;
    abs_b_in = (in_sgn && b[WIDTH-1]) ? -b : b;
    ext_a    = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    ext_b    = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    prod     = ext_a * ext_b;
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs_q};
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = op[1] ? S_DIV : S_MUL;
          sgn_d   = in_sgn;
          a_d     = a;
          b_d     = b;
          rem_d   = '0;
          quo_d   = abs_a_in;
          dvs_d   = abs_b_in;
          cnt_d   = '0;
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = prod;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (b_q == '0) begin
          state_d = S_DONE;
          hi_d    = a_q;
          lo_d    = '1;
        end else if (cnt_q == CW'(WIDTH)) begin
          // Sign fix: quotient negative on sign mismatch, remainder follows dividend
          state_d = S_DONE;
          lo_d    = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
          hi_d    = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
          cnt_d   = '0;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus control-sequence corner cases.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          cancel;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then count cycles until done; sampling on negedges.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit sync_first);
    int cyc;
    bit busy_ok;
    if (sync_first) @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(elat));
    check({name, " busy"}, {63'd0, busy_ok & ~busy}, 64'd1);
    check({name, " hi"}, 64'(hi), 64'(ehi));
    check({name, " lo"}, 64'(lo), 64'(elo));
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    bit saw_done;

    vecs.push_back('{"mult_neg2x3",  2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 3});
    vecs.push_back('{"multu_neg2x3", 2'b01, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 3});
    vecs.push_back('{"mult_minsq",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3});
    vecs.push_back('{"multu_maxsq",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3});
    vecs.push_back('{"div_m7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    vecs.push_back('{"divu_m7_2",    2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 34});
    vecs.push_back('{"div_min_m1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34});
    vecs.push_back('{"divu_min_m1",  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34});
    vecs.push_back('{"div_7_m2",     2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34});
    vecs.push_back('{"divu_100_7",   2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 34});
    vecs.push_back('{"divu_5_0",     2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 2});
    vecs.push_back('{"div_m5_0",     2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 2});

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].lat, 1'b1);

    // Start pulsed mid-divide is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cyc == 5) begin start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3; end
      if (cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("ignored_start latency", 64'(cyc), 64'd34);
    check("ignored_start hi", 64'(hi), 64'd2);
    check("ignored_start lo", 64'(lo), 64'd14);

    // Cancel in cycle 10 aborts with no done and keeps hi/lo
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel hi", 64'(hi), 64'd2);
    check("cancel lo", 64'(lo), 64'd14);
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check("cancel quiet", 64'(saw_done), 64'd0);

    // Start together with cancel is dropped
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("start_cancel busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("start_cancel done", 64'(done), 64'd0);

    // Back-to-back: new start accepted in the done cycle
    run_op("b2b_first", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 2, 1'b1);
    run_op("b2b_second", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 3, 1'b0);

    // Reset in mid-multiply
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFE; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("postreset done", 64'(done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
